// File: rtl/cron_pkg.sv
// -----------------------------------------------------------------------------
// cron_pkg
// Shared constants, types and helpers for the stopwatch display path.
//   - CRON_DIGITS / CRON_CNT_W / CRON_BCD_W : display geometry and widths
//   - SEG_* : 7-segment patterns {g,f,e,d,c,b,a}, active-high (1 = lit)
//   - bcd_state_e : state encoding of the sequential binary-to-BCD converter
//   - seg_decode() : BCD nibble -> active-high segment pattern
//   - bcd_add3()   : double-dabble correction step on a 4-nibble accumulator
// -----------------------------------------------------------------------------
package cron_pkg;

    localparam int CRON_DIGITS = 4;
    localparam int CRON_CNT_W  = 10;
    localparam int CRON_BCD_W  = 16;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_e;

    // Non-decimal nibbles (10..15) are shown as a dark digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Any nibble >= 5 would overflow past 9 after the next doubling, so it is
    // pre-corrected by +3 before the shift.
    function automatic logic [CRON_BCD_W-1:0] bcd_add3(input logic [CRON_BCD_W-1:0] acc);
        logic [CRON_BCD_W-1:0] res;
        res = acc;
        for (int i = 0; i < CRON_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 (double-dabble) converter, one bit per clock.
//   clk   in   1   clock
//   rst   in   1   synchronous reset, active-high
//   bin   in  10   binary value, captured when start is seen in IDLE
//   start in   1   begin a conversion (ignored unless IDLE)
//   busy  out  1   high in SHIFT and DONE
//   bcd   out 16   latched result {thousands,hundreds,tens,units}
//   done  out  1   one-cycle pulse while in DONE (bcd loads on that edge)
// Timing: start seen at edge E0, SHIFT on E1..E10, bcd loads at E11.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import cron_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CRON_CNT_W-1:0] bin,
    input  logic                  start,
    output logic                  busy,
    output logic [CRON_BCD_W-1:0] bcd,
    output logic                  done
);

    bcd_state_e            state_q, state_d;
    logic [CRON_CNT_W-1:0] sreg_q, sreg_d;
    logic [CRON_BCD_W-1:0] acc_q, acc_d;
    logic [CRON_BCD_W-1:0] acc_adj;
    logic [3:0]            cnt_q, cnt_d;
    logic [CRON_BCD_W-1:0] bcd_q, bcd_d;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done    = 1'b0;
        acc_adj = bcd_add3(acc_q);

        case (state_q)
            BCD_IDLE: begin
                if (start) begin
                    sreg_d  = bin;
                    acc_d   = '0;
                    cnt_d   = 4'd10;
                    state_d = BCD_SHIFT;
                end
            end
            BCD_SHIFT: begin
                // Correct, then shift {acc, sreg} left by one bit.
                acc_d  = {acc_adj[CRON_BCD_W-2:0], sreg_q[CRON_CNT_W-1]};
                sreg_d = {sreg_q[CRON_CNT_W-2:0], 1'b0};
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = BCD_DONE;
                end
            end
            BCD_DONE: begin
                bcd_d   = acc_q;
                done    = 1'b1;
                state_d = BCD_IDLE;
            end
            default: begin
                state_d = BCD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BCD_IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q != BCD_IDLE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/cron_display.sv
// -----------------------------------------------------------------------------
// cron_display
// Display back-end for the stopwatch: converts the 10-bit seconds count to BCD
// and scans it onto a four-digit multiplexed 7-segment display.
//   REFRESH_DIV  clk cycles per digit slot (>= 1)
//   ACTIVE_LOW   1: seg/an active-low, 0: active-high
//   clk   in   1   system clock
//   rst   in   1   synchronous reset, active-high
//   value in  10   binary count, 0..1023
//   seg   out  7   segment drive {g,f,e,d,c,b,a}
//   an    out  4   one-hot digit enable, bit 0 = units
//   bcd   out 16   latched BCD {thousands,hundreds,tens,units}
//   busy  out  1   conversion in progress
// Build option: define CRON_DISPLAY_LZB_EN for leading-zero blanking of
// digits 3..1 (digit 0 always shown; an keeps scanning all four digits).
// -----------------------------------------------------------------------------
module cron_display
    import cron_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CRON_CNT_W-1:0] value,
    output logic [6:0]            seg,
    output logic [3:0]            an,
    output logic [CRON_BCD_W-1:0] bcd,
    output logic                  busy
);

    localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic             INV      = (ACTIVE_LOW != 0);

    // Change detect: last_val holds the most recently converted value, pend
    // holds the value currently being converted.
    logic [CRON_CNT_W-1:0] last_val_q, last_val_d;
    logic [CRON_CNT_W-1:0] pend_q, pend_d;
    logic                  start;
    logic                  conv_busy;
    logic                  conv_done;
    logic [CRON_BCD_W-1:0] conv_bcd;

    logic [CNT_W-1:0]      refresh_cnt_q, refresh_cnt_d;
    logic [1:0]            digit_idx_q, digit_idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [3:0]            an_q, an_d;
    logic                  refresh_last;
    logic [3:0]            nib;
    logic                  blank;
    logic [6:0]            seg_ah;
    logic [3:0]            an_ah;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .bin   (value),
        .start (start),
        .busy  (conv_busy),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        start      = (value != last_val_q) && !conv_busy;
        pend_d     = start ? value : pend_q;
        last_val_d = conv_done ? pend_q : last_val_q;
    end

    always_comb begin
        refresh_last  = (refresh_cnt_q == CNT_LAST);
        refresh_cnt_d = refresh_last ? '0 : refresh_cnt_q + CNT_W'(1);
        digit_idx_d   = refresh_last ? digit_idx_q + 2'd1 : digit_idx_q;

        // seg and an are both derived from the next digit index so the
        // registered pair always agrees.
        nib   = conv_bcd[{digit_idx_d, 2'b00} +: 4];
        blank = 1'b0;
`ifdef CRON_DISPLAY_LZB_EN
        case (digit_idx_d)
            2'd3:    blank = (conv_bcd[15:12] == 4'd0);
            2'd2:    blank = (conv_bcd[15:8]  == 8'd0);
            2'd1:    blank = (conv_bcd[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
`endif
        seg_ah = blank ? SEG_BLANK : seg_decode(nib);
        an_ah  = 4'b0001 << digit_idx_d;
        seg_d  = INV ? ~seg_ah : seg_ah;
        an_d   = INV ? ~an_ah  : an_ah;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_val_q    <= '0;
            pend_q        <= '0;
            refresh_cnt_q <= '0;
            digit_idx_q   <= 2'd0;
            seg_q         <= INV ? ~SEG_0 : SEG_0;
            an_q          <= INV ? 4'b1110 : 4'b0001;
        end else begin
            last_val_q    <= last_val_d;
            pend_q        <= pend_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign bcd  = conv_bcd;
    assign busy = conv_busy;

endmodule

// File: tb/tb_cron_display.sv
// -----------------------------------------------------------------------------
// tb_cron_display
// Directed bench for cron_display with REFRESH_DIV=1, ACTIVE_LOW=1.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_cron_display;

    logic       clk;
    logic       rst;
    logic [9:0] value;
    logic [6:0] seg;
    logic [3:0] an;
    logic [15:0] bcd;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    cron_display #(
        .REFRESH_DIV (1),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .seg   (seg),
        .an    (an),
        .bcd   (bcd),
        .busy  (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Active-low reference patterns {g,f,e,d,c,b,a}.
    function automatic logic [6:0] exp_seg(input logic [3:0] d, input logic blank);
        logic [6:0] p;
        if (blank) return 7'b1111111;
        case (d)
            4'd0: p = 7'b1000000;
            4'd1: p = 7'b1111001;
            4'd2: p = 7'b0100100;
            4'd3: p = 7'b0110000;
            4'd4: p = 7'b0011001;
            4'd5: p = 7'b0010010;
            4'd6: p = 7'b0000010;
            4'd7: p = 7'b1111000;
            4'd8: p = 7'b0000000;
            4'd9: p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Watch four scan slots; for whichever digit is enabled, compare seg.
    task automatic check_scan(input string tag, input logic [15:0] digits);
        int idx;
        logic blank;
        for (int s = 0; s < 4; s++) begin
            tick();
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                check({tag, "_an_onehot"}, {12'd0, an}, 16'h000e);
            end else begin
                blank = 1'b0;
`ifdef CRON_DISPLAY_LZB_EN
                if (idx == 3) blank = (digits[15:12] == 4'd0);
                if (idx == 2) blank = (digits[15:8]  == 8'd0);
                if (idx == 1) blank = (digits[15:4]  == 12'd0);
`endif
                check($sformatf("%s_seg_d%0d", tag, idx), {9'd0, seg},
                      {9'd0, exp_seg(digits[4*idx +: 4], blank)});
            end
        end
    endtask

    // Full conversion from a quiet IDLE: E0 .. E11.
    task automatic convert(input string tag, input logic [9:0] v, input logic [15:0] exp);
        value = v;
        tick();                                   // E0
        check({tag, "_busy_e0"}, {15'd0, busy}, 16'h0001);
        repeat (10) tick();                       // E1..E10
        check({tag, "_busy_e10"}, {15'd0, busy}, 16'h0001);
        tick();                                   // E11
        check({tag, "_bcd_e11"}, bcd, exp);
        check({tag, "_busy_e11"}, {15'd0, busy}, 16'h0000);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst   = 1'b1;
        value = 10'd0;
        tick();
        tick();
        check("rst_busy", {15'd0, busy}, 16'h0000);
        check("rst_bcd",  bcd, 16'h0000);
        check("rst_an",   {12'd0, an}, 16'h000e);
        check("rst_seg",  {9'd0, seg}, 16'h0040);

        // Idle scan after reset: digit advances every cycle, all show '0'.
        rst = 1'b0;
        tick();
        check("scan_an1", {12'd0, an}, 16'h000d);
        check("scan_seg1", {9'd0, seg}, 16'h0040);
        tick();
        check("scan_an2", {12'd0, an}, 16'h000b);
        tick();
        check("scan_an3", {12'd0, an}, 16'h0007);
        check("scan_seg3", {9'd0, seg}, 16'h0040);
        tick();
        check("scan_an0", {12'd0, an}, 16'h000e);
        check("idle_busy", {15'd0, busy}, 16'h0000);

        // Maximum value.
        convert("v1023", 10'd1023, 16'h1023);
        check_scan("v1023", 16'h1023);
        repeat (3) tick();
        check("steady_busy", {15'd0, busy}, 16'h0000);

        // Input changes mid-conversion: 57 completes, then 58 follows at E12.
        value = 10'd57;
        tick();                                   // E0
        tick();                                   // E1
        tick();                                   // E2
        value = 10'd58;                           // seen from E3 on
        repeat (8) tick();                        // E3..E10
        check("chg_bcd_e10", bcd, 16'h1023);
        tick();                                   // E11
        check("chg_bcd_e11", bcd, 16'h0057);
        check("chg_busy_e11", {15'd0, busy}, 16'h0000);
        tick();                                   // E12 = next E0
        check("chg_busy_e12", {15'd0, busy}, 16'h0001);
        repeat (10) tick();                       // E13..E22
        check("chg_bcd_e22", bcd, 16'h0057);
        tick();                                   // E23
        check("chg_bcd_e23", bcd, 16'h0058);
        check("chg_busy_e23", {15'd0, busy}, 16'h0000);

        // Reset in the middle of converting 999.
        value = 10'd999;
        repeat (6) tick();                        // E0..E5
        check("mid_busy_e5", {15'd0, busy}, 16'h0001);
        rst = 1'b1;
        tick();
        check("mid_rst_bcd",  bcd, 16'h0000);
        check("mid_rst_busy", {15'd0, busy}, 16'h0000);
        check("mid_rst_an",   {12'd0, an}, 16'h000e);
        check("mid_rst_seg",  {9'd0, seg}, 16'h0040);
        rst = 1'b0;
        convert("v999", 10'd999, 16'h0999);
        check_scan("v999", 16'h0999);

        convert("v7", 10'd7, 16'h0007);
        check_scan("v7", 16'h0007);

        convert("v100", 10'd100, 16'h0100);
        check_scan("v100", 16'h0100);

        convert("v1000", 10'd1000, 16'h1000);
        convert("v0", 10'd0, 16'h0000);
        convert("v1", 10'd1, 16'h0001);
        convert("v509", 10'd509, 16'h0509);
        check_scan("v509", 16'h0509);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
